// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration bitstream loader.
//   state_e       : loader FSM states
//   CrcPoly/Init  : CRC-8 used for readback comparison
//   words_needed  : host words required to fill a chain of a given length
package cfg_loader_pkg;

   typedef enum logic [1:0] {StIdle, StLoad, StVerify, StDone} state_e;

   localparam logic [7:0] CrcPoly = 8'h07;
   localparam logic [7:0] CrcInit = 8'h00;

   function automatic int unsigned words_needed(input int unsigned chain_len,
                                                input int unsigned word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (MSB-first register, one input bit per enabled cycle).
// Ports:
//   prog_clk, rst : clock, async active-low reset
//   en            : fold din into the CRC this cycle
//   clr           : reload the initial value (wins over en)
//   din           : serial input bit
//   crc           : current CRC value
//   crc_next      : value the register takes at the coming edge
module crc8_serial
   import cfg_loader_pkg::*;
(
   input  logic       prog_clk,
   input  logic       rst,
   input  logic       en,
   input  logic       clr,
   input  logic       din,
   output logic [7:0] crc,
   output logic [7:0] crc_next
);

   logic [7:0] crc_q;
   logic       fb;

   always_comb begin
      fb       = crc_q[7] ^ din;
      crc_next = crc_q;
      if (clr) begin
         crc_next = CrcInit;
      end else if (en) begin
         crc_next = {crc_q[6:0], 1'b0} ^ (fb ? CrcPoly : 8'h00);
      end
   end

   always_ff @(posedge prog_clk or negedge rst) begin
      if (!rst) crc_q <= CrcInit;
      else      crc_q <= crc_next;
   end

   assign crc = crc_q;

endmodule

// File: rtl/cfg_bitstream_loader.sv
// Serial configuration-chain driver. Accepts host words on a valid/ready
// stream and shifts them LSB-first onto prog_in, one bit per prog_en cycle.
// Optional readback (macro CFG_LOADER_READBACK_EN): a second identical pass
// is shifted while prog_out is CRC'd and compared against the first pass.
// Ports:
//   prog_clk, rst          : clock, async active-low reset
//   start                  : begin a load (ignored while busy)
//   word_data/valid/ready  : host word stream, bit 0 shifted first
//   prog_in, prog_en       : serial data and shift enable to chain head
//   prog_out               : chain tail, readback only
//   busy, done, error      : status; error is sticky readback mismatch
module cfg_bitstream_loader
   import cfg_loader_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 20,
   parameter int unsigned WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              prog_in,
   output logic              prog_en,
   input  logic              prog_out,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int unsigned NumWords = words_needed(CHAIN_LEN, WORD_W);
   localparam int unsigned BitW     = $clog2(CHAIN_LEN);
   localparam int unsigned WcntW    = $clog2(WORD_W + 1);
   localparam int unsigned WordsW   = $clog2(NumWords + 1);

   state_e              state_q, state_d;
   logic [BitW-1:0]     bcnt_q, bcnt_d;
   logic [WcntW-1:0]    wcnt_q, wcnt_d;
   logic [WORD_W-1:0]   sh_q, sh_d;
   logic [WordsW-1:0]   words_q, words_d;
   logic                prog_in_q, prog_in_d;
   logic                prog_en_q, prog_en_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                in_pass, accept, bit_avail, bit_val;

`ifdef CFG_LOADER_READBACK_EN
   logic       verify_q;
   logic       crc_clr;
   logic [7:0] crc_a, crc_a_next, crc_b, crc_b_next;
`else
   logic       unused_prog_out;
   assign unused_prog_out = prog_out;
`endif

   assign in_pass    = (state_q == StLoad) || (state_q == StVerify);
   // Ready while the shifter is empty or on its last bit, so a new word can
   // be loaded without a gap in prog_en.
   assign word_ready = in_pass && (words_q < WordsW'(NumWords)) && (wcnt_q <= WcntW'(1));
   assign accept     = word_valid && word_ready;

   always_comb begin
      state_d   = state_q;
      bcnt_d    = bcnt_q;
      wcnt_d    = wcnt_q;
      sh_d      = sh_q;
      words_d   = words_q;
      prog_in_d = prog_in_q;
      prog_en_d = 1'b0;
      done_d    = 1'b0;
      error_d   = error_q;
      bit_avail = 1'b0;
      bit_val   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoad;
               bcnt_d  = '0;
               wcnt_d  = '0;
               sh_d    = '0;
               words_d = '0;
               error_d = 1'b0;
            end
         end
         StLoad, StVerify: begin
            if (wcnt_q != '0) begin
               bit_avail = 1'b1;
               bit_val   = sh_q[0];
               sh_d      = sh_q >> 1;
               wcnt_d    = wcnt_q - WcntW'(1);
            end
            if (accept) begin
               words_d = words_q + WordsW'(1);
               if (wcnt_q == '0) begin
                  // Empty shifter: bit 0 goes straight out this edge.
                  bit_avail = 1'b1;
                  bit_val   = word_data[0];
                  sh_d      = word_data >> 1;
                  wcnt_d    = WcntW'(WORD_W - 1);
               end else begin
                  sh_d   = word_data;
                  wcnt_d = WcntW'(WORD_W);
               end
            end
            if (bit_avail) begin
               prog_en_d = 1'b1;
               prog_in_d = bit_val;
               bcnt_d    = bcnt_q + BitW'(1);
               if (bcnt_q == BitW'(CHAIN_LEN - 1)) begin
                  // Last chain bit: drop any leftover bits of the final word.
                  bcnt_d  = '0;
                  wcnt_d  = '0;
                  sh_d    = '0;
                  words_d = '0;
`ifdef CFG_LOADER_READBACK_EN
                  state_d = (state_q == StLoad) ? StVerify : StDone;
`else
                  state_d = StDone;
`endif
               end
            end
         end
         StDone: begin
            done_d  = 1'b1;
            state_d = StIdle;
`ifdef CFG_LOADER_READBACK_EN
            // The final readback bit is folded into CRC B at this same edge.
            error_d = (crc_a != crc_b_next);
`endif
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge prog_clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         bcnt_q    <= '0;
         wcnt_q    <= '0;
         sh_q      <= '0;
         words_q   <= '0;
         prog_in_q <= 1'b0;
         prog_en_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         bcnt_q    <= bcnt_d;
         wcnt_q    <= wcnt_d;
         sh_q      <= sh_d;
         words_q   <= words_d;
         prog_in_q <= prog_in_d;
         prog_en_q <= prog_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

`ifdef CFG_LOADER_READBACK_EN
   // Marks that the prog_en currently presented belongs to the verify pass.
   always_ff @(posedge prog_clk or negedge rst) begin
      if (!rst) verify_q <= 1'b0;
      else      verify_q <= prog_en_d && (state_q == StVerify);
   end

   assign crc_clr = (state_q == StIdle) && start;

   crc8_serial u_crc_a (
      .prog_clk (prog_clk),
      .rst      (rst),
      .en       (bit_avail && (state_q == StLoad)),
      .clr      (crc_clr),
      .din      (bit_val),
      .crc      (crc_a),
      .crc_next (crc_a_next)
   );

   crc8_serial u_crc_b (
      .prog_clk (prog_clk),
      .rst      (rst),
      .en       (verify_q),
      .clr      (crc_clr),
      .din      (prog_out),
      .crc      (crc_b),
      .crc_next (crc_b_next)
   );

   logic unused_crc;
   assign unused_crc = ^{crc_a_next, crc_b};
`endif

   assign prog_in = prog_in_q;
   assign prog_en = prog_en_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign error   = error_q;

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
module tb_cfg_bitstream_loader;

   localparam int L  = 20;
   localparam int W  = 8;
   localparam int NW = (L + W - 1) / W;
`ifdef CFG_LOADER_READBACK_EN
   localparam int Passes = 2;
`else
   localparam int Passes = 1;
`endif

   logic         prog_clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] word_data = '0;
   logic         word_valid = 1'b0;
   logic         word_ready, prog_in, prog_en, prog_out, busy, done, error;

   always #5 prog_clk = ~prog_clk;

   cfg_bitstream_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
      .prog_clk   (prog_clk),
      .rst        (rst),
      .start      (start),
      .word_data  (word_data),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .prog_in    (prog_in),
      .prog_en    (prog_en),
      .prog_out   (prog_out),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   // Reference chain: shifts toward prog_out on every prog_en edge.
   logic [L-1:0] chain = '0;
   assign prog_out = chain[0];

   logic mon_clr = 1'b0;
   logic flip_en = 1'b0;
   int   cyc = 0, en_cnt = 0, done_cnt = 0, first_en = -1, last_en = -1, done_cyc = -1;
   logic done_busy = 1'b0;
   logic stream[$];

   always @(posedge prog_clk) begin
      cyc <= cyc + 1;
      if (mon_clr) begin
         en_cnt    <= 0;
         done_cnt  <= 0;
         first_en  <= -1;
         last_en   <= -1;
         done_cyc  <= -1;
         done_busy <= 1'b0;
         stream.delete();
      end else begin
         if (prog_en) begin
            en_cnt <= en_cnt + 1;
            if (first_en < 0) first_en <= cyc;
            last_en <= cyc;
            stream.push_back(prog_in);
         end
         if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            if (busy) done_busy <= 1'b1;
         end
      end
      // Optional corruption of chain bit 7 just before the second pass.
      if (prog_en)
         chain <= {prog_in, chain[L-1:1] ^
                   ((flip_en && en_cnt == L) ? (L-1)'(1 << 6) : (L-1)'(0))};
   end

   int n_pass = 0, n_chk = 0, n_fail = 0;
   logic [W-1:0] words [NW];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
   endtask

   // Sends the NW words; word sw is withheld for sl cycles in which ready is high.
   task automatic send_pass(input int sw, input int sl, input bit mid_start);
      for (int i = 0; i < NW; i++) begin
         int k = 0;
         int guard = 0;
         bit acc = 1'b0;
         word_data = words[i];
         while (!acc && guard < 200) begin
            word_valid = (i != sw) || (k >= sl);
            if (mid_start && i == 1 && guard == 0) start = 1'b1;
            if (word_ready && word_valid) acc = 1'b1;
            else if (word_ready) k++;
            tick();
            start = 1'b0;
            guard++;
         end
         word_valid = 1'b0;
         chk("word_accept", {31'd0, acc}, 32'd1);
      end
   endtask

   task automatic wait_done();
      int guard = 0;
      while (done_cnt == 0 && guard < 100) begin
         tick();
         guard++;
      end
      chk("done_seen", {31'd0, done_cnt != 0}, 32'd1);
      tick();
      tick();
   endtask

   task automatic run_load(input int sw, input int sl, input bit ms, input bit fl,
                           input bit exp_err);
      logic [31:0] exp_chain;
      int          errs;
      int          exp_bub;
      clear_mon();
      flip_en = fl;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("ready_after_start", {31'd0, word_ready}, 32'd1);
      chk("error_cleared", {31'd0, error}, 32'd0);
      send_pass(sw, sl, ms);
      if (Passes == 2) send_pass(-1, 0, 1'b0);
      wait_done();
      flip_en = 1'b0;

      exp_chain = '0;
      for (int i = 0; i < NW; i++) exp_chain = exp_chain | (32'(words[i]) << (W * i));
      exp_chain = exp_chain & ((32'd1 << L) - 32'd1);
      // A withheld later word still lets the shifter's last bit go out in the
      // first ready cycle, so only the remaining withheld cycles are gaps.
      exp_bub = (sw >= 1 && sl > 0) ? sl - 1 : 0;
      errs = 0;
      for (int j = 0; j < stream.size(); j++)
         if (stream[j] !== words[(j % L) / W][(j % L) % W]) errs++;

      chk("en_count", en_cnt, L * Passes);
      chk("stream_len", stream.size(), L * Passes);
      chk("stream_bits", errs, 0);
      chk("chain", {{(32 - L){1'b0}}, chain}, exp_chain);
      chk("done_count", done_cnt, 1);
      chk("done_timing", done_cyc, last_en + 1);
      chk("busy_in_done", {31'd0, done_busy}, 32'd0);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("gaps", (last_en - first_en + 1) - en_cnt, exp_bub);
      chk("error", {31'd0, error}, {31'd0, exp_err});
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_prog_en"}, {31'd0, prog_en}, 32'd0);
      chk({tag, "_prog_in"}, {31'd0, prog_in}, 32'd0);
      chk({tag, "_word_ready"}, {31'd0, word_ready}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_error"}, {31'd0, error}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      check_idle_outputs("reset");
      tick();
      rst = 1'b1;
      tick();

      // Basic directed load.
      words[0] = 8'hA5;
      words[1] = 8'h3C;
      words[2] = 8'h0F;
      run_load(-1, 0, 1'b0, 1'b0, 1'b0);
      chk("basic_chain", {12'd0, chain}, 32'h000F3CA5);

      // Word 1 withheld: three prog_en gaps expected.
      run_load(1, 4, 1'b0, 1'b0, 1'b0);

      // start pulsed while busy.
      run_load(-1, 0, 1'b1, 1'b0, 1'b0);

      // Reset after nine shifted bits, then a clean reload.
      begin
         int idx = 0;
         int guard = 0;
         words[0] = 8'h5A;
         words[1] = 8'hC3;
         words[2] = 8'h06;
         clear_mon();
         start = 1'b1;
         tick();
         start = 1'b0;
         while (en_cnt < 9 && guard < 100) begin
            word_data  = words[idx];
            word_valid = 1'b1;
            if (word_ready) idx++;
            tick();
            guard++;
         end
         chk("mid_reset_reached", {31'd0, en_cnt == 9}, 32'd1);
         #2 rst = 1'b0;
         #1;
         check_idle_outputs("mid_reset");
         word_valid = 1'b0;
         tick();
         rst = 1'b1;
         tick();
         run_load(-1, 0, 1'b0, 1'b0, 1'b0);
      end

`ifdef CFG_LOADER_READBACK_EN
      // Corrupted chain between passes, then a clean load clears error.
      run_load(-1, 0, 1'b0, 1'b1, 1'b1);
      run_load(-1, 0, 1'b0, 1'b0, 1'b0);
`endif

      // Randomized loads with random stalls.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NW; i++) words[i] = W'($urandom);
         run_load(int'($urandom_range(0, NW - 1)), int'($urandom_range(0, 5)), 1'b0, 1'b0,
                  1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
